cdm_mult_pipe: RTL and testbench



---
 rtl/cdm_mult_pipe.sv | 259 +++++++++++++++++++++++++
 tb/tb_cdm_mult_pipe.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdm_mult_pipe.sv
// ============================================================================
// cdm_mult_pipe
// ----------------------------------------------------------------------------
// Pipelined carry-disregard approximate multiplier with a valid/ready stream
// interface, a per-beat exact/approximate mode, a per-result error output
// and running error statistics.
//
// Approximate product (mode = 0):
//   * product columns c < K: the result bit is the OR of every partial
//     product bit in that column, and no carry leaves the column;
//   * product columns c >= K: the partial products of those columns are
//     summed exactly, truncated to the 2W-bit product width.
// Exact product (mode = 1): R = A * B.
// Error: E = A * B - R, which is never negative.
//
// Pipeline (one global advance enable, bubbles are not collapsed):
//   stage 1 : register A, B, mode
//   stage 2 : low-column OR vector, high-column partial sum, exact product
//   stage 3 : select R, compute E, registered outputs
//
// Parameters
//   W  : operand width (2..32)
//   K  : number of low product columns with carries disregarded (0..2W)
//   CW : statistics counter width
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    operand beat valid
//   in_ready   out  1    block accepts beat (= advance enable)
//   A          in   W    multiplicand, unsigned
//   B          in   W    multiplier, unsigned
//   mode       in   1    0 = approximate, 1 = exact
//   out_valid  out  1    result valid
//   out_ready  in   1    consumer accepts result
//   R          out  2W   product (approximate or exact)
//   E          out  2W   exact product minus R
//   clr_stats  in   1    synchronous clear of statistics
//   txn_cnt    out  CW   completed output transactions (wraps)
//   err_acc    out  CW   saturating sum of E over completed transactions
// ============================================================================
module cdm_mult_pipe #(
    parameter int W  = 8,
    parameter int K  = 9,
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  logic            mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  R,
    output logic [2*W-1:0]  E,
    input  logic            clr_stats,
    output logic [CW-1:0]   txn_cnt,
    output logic [CW-1:0]   err_acc
);

    localparam int PW = 2 * W;
    // Wide enough to hold err_acc + E without wrapping, so saturation is exact.
    localparam int SW = ((CW > PW) ? CW : PW) + 1;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // Mask of the product columns that keep exact carry propagation (c >= K).
    function automatic logic [PW-1:0] hi_mask_f();
        logic [PW-1:0] m;
        m = {PW{1'b0}};
        for (int c = 0; c < PW; c++) begin
            if (c >= K) begin
                m[c] = 1'b1;
            end else begin
                m[c] = 1'b0;
            end
        end
        return m;
    endfunction

    localparam logic [PW-1:0] HI_MASK = hi_mask_f();

    // Column-wise OR of the partial products, restricted to columns c < K.
    function automatic logic [PW-1:0] col_or_f(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [PW-1:0] v;
        v = {PW{1'b0}};
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                v[i+j] = v[i+j] | (a[i] & b[j]);
            end
        end
        return v & ~HI_MASK;
    endfunction

    // Exact sum of the partial products whose column is >= K. Each row is
    // b shifted by i with its low columns masked off, so the result has only
    // zeros below column K and can be ORed with the low-column vector.
    // This sum never exceeds A*B, so it always fits in 2W bits.
    function automatic logic [PW-1:0] hi_sum_f(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [PW-1:0] s;
        logic [PW-1:0] row;
        s = {PW{1'b0}};
        for (int i = 0; i < W; i++) begin
            row = ({{W{1'b0}}, b} << i) & HI_MASK;
            s   = s + (a[i] ? row : {PW{1'b0}});
        end
        return s;
    endfunction

    // Full-width exact product.
    function automatic logic [PW-1:0] exact_f(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic            r_s1_v;
    logic [W-1:0]    r_s1_a;
    logic [W-1:0]    r_s1_b;
    logic            r_s1_mode;

    logic            r_s2_v;
    logic [PW-1:0]   r_s2_lo;
    logic [PW-1:0]   r_s2_hi;
    logic [PW-1:0]   r_s2_exact;
    logic            r_s2_mode;

    logic            r_out_v;
    logic [PW-1:0]   r_r;
    logic [PW-1:0]   r_e;

    logic [CW-1:0]   r_txn_cnt;
    logic [CW-1:0]   r_err_acc;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic            w_adv;
    logic            w_hs;
    logic [PW-1:0]   w_r_sel;
    logic [PW-1:0]   w_e;
    logic [SW-1:0]   w_err_sum;
    logic [CW-1:0]   w_err_next;

    localparam logic [SW-1:0] CNT_MAX = SW'({CW{1'b1}});

    // Global advance enable and output handshake.
    always_comb begin
        w_adv = 1'b0;
        w_hs  = 1'b0;
        w_adv = (~r_out_v) | out_ready;
        w_hs  = r_out_v & out_ready;
    end

    // Stage 3 datapath: result select and error.
    always_comb begin
        w_r_sel = {PW{1'b0}};
        w_e     = {PW{1'b0}};
        if (r_s2_mode) begin
            w_r_sel = r_s2_exact;
        end else begin
            w_r_sel = r_s2_hi | r_s2_lo;
        end
        w_e = r_s2_exact - w_r_sel;
    end

    // Saturating next value of the error accumulator.
    always_comb begin
        w_err_sum  = {SW{1'b0}};
        w_err_next = {CW{1'b0}};
        w_err_sum  = SW'(r_err_acc) + SW'(r_e);
        if (w_err_sum > CNT_MAX) begin
            w_err_next = {CW{1'b1}};
        end else begin
            w_err_next = w_err_sum[CW-1:0];
        end
    end

    // Stage 1: capture operands; data only loads when a beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_a    <= {W{1'b0}};
            r_s1_b    <= {W{1'b0}};
            r_s1_mode <= 1'b0;
        end else if (w_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_a    <= A;
                r_s1_b    <= B;
                r_s1_mode <= mode;
            end
        end
    end

    // Stage 2: low-column OR vector, high-column sum and exact product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v     <= 1'b0;
            r_s2_lo    <= {PW{1'b0}};
            r_s2_hi    <= {PW{1'b0}};
            r_s2_exact <= {PW{1'b0}};
            r_s2_mode  <= 1'b0;
        end else if (w_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_lo    <= col_or_f(r_s1_a, r_s1_b);
                r_s2_hi    <= hi_sum_f(r_s1_a, r_s1_b);
                r_s2_exact <= exact_f(r_s1_a, r_s1_b);
                r_s2_mode  <= r_s1_mode;
            end
        end
    end

    // Stage 3: registered outputs; R/E hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
            r_r     <= {PW{1'b0}};
            r_e     <= {PW{1'b0}};
        end else if (w_adv) begin
            r_out_v <= r_s2_v;
            if (r_s2_v) begin
                r_r <= w_r_sel;
                r_e <= w_e;
            end
        end
    end

    // Statistics: clear has priority over a completing handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_cnt <= {CW{1'b0}};
            r_err_acc <= {CW{1'b0}};
        end else if (clr_stats) begin
            r_txn_cnt <= {CW{1'b0}};
            r_err_acc <= {CW{1'b0}};
        end else if (w_hs) begin
            r_txn_cnt <= r_txn_cnt + CW'(1'b1);
            r_err_acc <= w_err_next;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_v;
    assign R         = r_r;
    assign E         = r_e;
    assign txn_cnt   = r_txn_cnt;
    assign err_acc   = r_err_acc;

endmodule

// File: tb/tb_cdm_mult_pipe.sv
// ============================================================================
// tb_cdm_mult_pipe
// Self-checking bench for cdm_mult_pipe. Four instances share one stimulus
// stream: K=9/CW=32 (main), K=0, K=16 and K=9/CW=4 (saturation). A
// scoreboard queue is filled from a column-count model whenever a beat is
// accepted and drained whenever a result handshake completes.
// ============================================================================
module tb_cdm_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        mode;
    logic        out_ready;
    logic        clr_stats;
    logic [7:0]  A;
    logic [7:0]  B;

    logic        in_ready,  out_valid;
    logic [15:0] R, E;
    logic [31:0] txn_cnt, err_acc;

    logic        in_ready_k0, out_valid_k0;
    logic [15:0] R_k0, E_k0;
    logic [31:0] txn_k0, err_k0;

    logic        in_ready_k16, out_valid_k16;
    logic [15:0] R_k16, E_k16;
    logic [31:0] txn_k16, err_k16;

    logic        in_ready_c4, out_valid_c4;
    logic [15:0] R_c4, E_c4;
    logic [3:0]  txn_c4, err_c4;

    always #5 clk = ~clk;

    cdm_mult_pipe #(.W(8), .K(9), .CW(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .E(E), .clr_stats(clr_stats), .txn_cnt(txn_cnt), .err_acc(err_acc));

    cdm_mult_pipe #(.W(8), .K(0), .CW(32)) dut_k0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_k0),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid_k0), .out_ready(out_ready),
        .R(R_k0), .E(E_k0), .clr_stats(clr_stats), .txn_cnt(txn_k0), .err_acc(err_k0));

    cdm_mult_pipe #(.W(8), .K(16), .CW(32)) dut_k16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_k16),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid_k16), .out_ready(out_ready),
        .R(R_k16), .E(E_k16), .clr_stats(clr_stats), .txn_cnt(txn_k16), .err_acc(err_k16));

    cdm_mult_pipe #(.W(8), .K(9), .CW(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c4),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid_c4), .out_ready(out_ready),
        .R(R_c4), .E(E_c4), .clr_stats(clr_stats), .txn_cnt(txn_c4), .err_acc(err_c4));

    typedef struct {
        logic [15:0] r9, e9, r0, e0, r16, e16;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
    } stim_t;

    exp_t  sb_q[$];
    stim_t st_q[$];

    int tests = 0;
    int fails = 0;

    logic [63:0] m_txn, m_err, m_err16, m_txn4, m_err4;

    // Column-count reference model of the carry-disregard product.
    function automatic logic [15:0] model_r(input logic [7:0] a, input logic [7:0] b,
                                            input logic m, input int k);
        int cnt[16];
        int r;
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        if (m) begin
            r = ia * ib;
        end else begin
            for (int c = 0; c < 16; c++) cnt[c] = 0;
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if (a[i] && b[j]) cnt[i+j] = cnt[i+j] + 1;
            for (int c = 0; c < 16; c++) begin
                if (c < k) begin
                    if (cnt[c] > 0) r = r + (1 << c);
                end else begin
                    r = r + (cnt[c] << c);
                end
            end
        end
        return r[15:0];
    endfunction

    function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b, input logic m);
        exp_t x;
        logic [15:0] ex;
        ex    = model_r(a, b, 1'b1, 0);
        x.r9  = model_r(a, b, m, 9);
        x.e9  = ex - x.r9;
        x.r0  = model_r(a, b, m, 0);
        x.e0  = ex - x.r0;
        x.r16 = model_r(a, b, m, 16);
        x.e16 = ex - x.r16;
        return x;
    endfunction

    // Scoreboard monitor: samples at the falling edge, away from the active edge.
    bit   hs;
    bit   got;
    exp_t ex_c;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                m_txn = 64'd0; m_err = 64'd0; m_err16 = 64'd0;
                m_txn4 = 64'd0; m_err4 = 64'd0;
            end else begin
                tests++;
                if (txn_cnt !== m_txn[31:0] || err_acc !== m_err[31:0]) begin
                    fails++;
                    $display("FAIL stats: txn=%0d err=%0d, expected txn=%0d err=%0d",
                             txn_cnt, err_acc, m_txn[31:0], m_err[31:0]);
                end
                tests++;
                if (txn_c4 !== m_txn4[3:0] || err_c4 !== m_err4[3:0]) begin
                    fails++;
                    $display("FAIL stats_cw4: txn=%0d err=%0d, expected txn=%0d err=%0d",
                             txn_c4, err_c4, m_txn4[3:0], m_err4[3:0]);
                end
                tests++;
                if (txn_k0 !== m_txn[31:0] || txn_k16 !== m_txn[31:0] ||
                    err_k0 !== 32'd0 || err_k16 !== m_err16[31:0]) begin
                    fails++;
                    $display("FAIL stats_k: txn_k0=%0d txn_k16=%0d err_k0=%0d err_k16=%0d, expected txn=%0d err_k0=0 err_k16=%0d",
                             txn_k0, txn_k16, err_k0, err_k16, m_txn[31:0], m_err16[31:0]);
                end
                tests++;
                if ({out_valid_k0, out_valid_k16, out_valid_c4, in_ready_k0, in_ready_k16, in_ready_c4}
                    !== {out_valid, out_valid, out_valid, in_ready, in_ready, in_ready}) begin
                    fails++;
                    $display("FAIL handshake_sync: instances disagree, out_valid=%b in_ready=%b",
                             out_valid, in_ready);
                end
                hs  = out_valid && out_ready;
                got = 1'b0;
                if (hs) begin
                    tests++;
                    if (sb_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output: R=%0d E=%0d with empty scoreboard", R, E);
                    end else begin
                        ex_c = sb_q.pop_front();
                        got  = 1'b1;
                        if (R !== ex_c.r9 || E !== ex_c.e9 || R_c4 !== ex_c.r9 || E_c4 !== ex_c.e9) begin
                            fails++;
                            $display("FAIL result_k9: R=%0d E=%0d, expected R=%0d E=%0d",
                                     R, E, ex_c.r9, ex_c.e9);
                        end
                        tests++;
                        if (R_k0 !== ex_c.r0 || E_k0 !== ex_c.e0) begin
                            fails++;
                            $display("FAIL result_k0: R=%0d E=%0d, expected R=%0d E=%0d",
                                     R_k0, E_k0, ex_c.r0, ex_c.e0);
                        end
                        tests++;
                        if (R_k16 !== ex_c.r16 || E_k16 !== ex_c.e16) begin
                            fails++;
                            $display("FAIL result_k16: R=%0d E=%0d, expected R=%0d E=%0d",
                                     R_k16, E_k16, ex_c.r16, ex_c.e16);
                        end
                    end
                end
                if (clr_stats) begin
                    m_txn = 64'd0; m_err = 64'd0; m_err16 = 64'd0;
                    m_txn4 = 64'd0; m_err4 = 64'd0;
                end else if (got) begin
                    m_txn   = (m_txn + 64'd1) & 64'hFFFF_FFFF;
                    m_err   = m_err + 64'(ex_c.e9);
                    if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
                    m_err16 = m_err16 + 64'(ex_c.e16);
                    if (m_err16 > 64'hFFFF_FFFF) m_err16 = 64'hFFFF_FFFF;
                    m_txn4  = (m_txn4 + 64'd1) & 64'hF;
                    m_err4  = m_err4 + 64'(ex_c.e9);
                    if (m_err4 > 64'd15) m_err4 = 64'd15;
                end
                if (in_valid && in_ready) sb_q.push_back(make_exp(A, B, mode));
            end
        end
    end

    // Global time limit.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: called at posedge+1, streams st_q then drains the scoreboard.
    task automatic drive_stream(input int ready_pct, input int limit, output bit timed_out);
        int  cyc;
        bit  acc;
        cyc = 0;
        while (st_q.size() > 0 && cyc < limit) begin
            A = st_q[0].a; B = st_q[0].b; mode = st_q[0].m;
            in_valid  = 1'b1;
            out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; cyc++;
            if (acc) void'(st_q.pop_front());
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() > 0 && cyc < limit) begin
            @(posedge clk); #1; cyc++;
        end
        timed_out = (cyc >= limit);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
        A = 8'd0; B = 8'd0; mode = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if (out_valid !== 1'b0 || R !== 16'd0 || E !== 16'd0 || txn_cnt !== 32'd0 || err_acc !== 32'd0) begin
            fails++;
            $display("FAIL reset_values: out_valid=%b R=%0d E=%0d txn=%0d err=%0d, expected all 0",
                     out_valid, R, E, txn_cnt, err_acc);
        end
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [3];
        logic [7:0]  tb_ [3];
        logic        tm [3];
        logic [15:0] xr [3][3];
        logic [15:0] xe [3][3];
        ta[0] = 8'd255; tb_[0] = 8'd255; tm[0] = 1'b0;
        xr[0][0] = 16'd61951; xe[0][0] = 16'd3074;
        xr[0][1] = 16'd65025; xe[0][1] = 16'd0;
        xr[0][2] = 16'd32767; xe[0][2] = 16'd32258;
        ta[1] = 8'd3; tb_[1] = 8'd3; tm[1] = 1'b0;
        xr[1][0] = 16'd7;  xe[1][0] = 16'd2;
        xr[1][1] = 16'd9;  xe[1][1] = 16'd0;
        xr[1][2] = 16'd7;  xe[1][2] = 16'd2;
        ta[2] = 8'd255; tb_[2] = 8'd255; tm[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin xr[2][k] = 16'd65025; xe[2][k] = 16'd0; end
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            A = ta[n]; B = tb_[n]; mode = tm[n]; in_valid = 1'b1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL directed_in_ready[%0d]: got %b expected 1", n, in_ready);
            end
            @(posedge clk); #1 in_valid = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL latency_early[%0d]: out_valid=%b expected 0 two edges after acceptance", n, out_valid);
            end
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || R !== xr[n][0] || E !== xe[n][0]) begin
                fails++;
                $display("FAIL directed_k9[%0d]: out_valid=%b R=%0d E=%0d, expected 1 R=%0d E=%0d",
                         n, out_valid, R, E, xr[n][0], xe[n][0]);
            end
            tests++;
            if (R_k0 !== xr[n][1] || E_k0 !== xe[n][1] || R_k16 !== xr[n][2] || E_k16 !== xe[n][2]) begin
                fails++;
                $display("FAIL directed_bounds[%0d]: K0 R=%0d E=%0d K16 R=%0d E=%0d, expected K0 %0d/%0d K16 %0d/%0d",
                         n, R_k0, E_k0, R_k16, E_k16, xr[n][1], xe[n][1], xr[n][2], xe[n][2]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep();
        stim_t s;
        bit    to;
        int    n;
        do_reset();
        n = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b += 5) begin
                s.a = a[7:0]; s.b = b[7:0]; s.m = 1'b0;
                st_q.push_back(s);
                n++;
            end
        end
        drive_stream(50, 60000, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL sweep_timeout: %0d beats still queued, %0d results pending", st_q.size(), sb_q.size());
        end
        tests++;
        if (txn_cnt !== n[31:0] || err_acc !== m_err[31:0]) begin
            fails++;
            $display("FAIL sweep_stats: txn=%0d err=%0d, expected txn=%0d err=%0d", txn_cnt, err_acc, n, m_err[31:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  va [6];
        logic [15:0] hr, he;
        bit          have, acc, to;
        int          idx;
        stim_t       s;
        for (int i = 0; i < 6; i++) va[i] = 8'(8'd37 * i + 8'd11);
        have = 1'b0; idx = 0; hr = 16'd0; he = 16'd0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            A = va[idx]; B = 8'd200 - va[idx]; mode = 1'b0;
            in_valid = 1'b1; out_ready = 1'b0;
            @(negedge clk); acc = in_ready;
            if (out_valid) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
                if (!have) begin
                    have = 1'b1; hr = R; he = E;
                end else begin
                    tests++;
                    if (R !== hr || E !== he) begin
                        fails++;
                        $display("FAIL stall_hold: R=%0d E=%0d, expected R=%0d E=%0d", R, E, hr, he);
                    end
                end
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        tests++;
        if (idx !== 3 || sb_q.size() !== 3) begin
            fails++;
            $display("FAIL in_flight: accepted=%0d in scoreboard=%0d, expected 3 and 3", idx, sb_q.size());
        end
        for (int i = idx; i < 6; i++) begin
            s.a = va[i]; s.b = 8'd200 - va[i]; s.m = 1'b0;
            st_q.push_back(s);
        end
        drive_stream(100, 200, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL backpressure_timeout: results pending %0d", sb_q.size());
        end
    endtask

    task automatic test_clr_stats();
        do_reset();
        out_ready = 1'b1;
        A = 8'd3; B = 8'd3; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 A = 8'd255; B = 8'd255;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || txn_cnt !== 32'd1 || err_acc !== 32'd2) begin
            fails++;
            $display("FAIL pre_clear: out_valid=%b txn=%0d err=%0d, expected 1, 1, 2", out_valid, txn_cnt, err_acc);
        end
        clr_stats = 1'b1;
        @(posedge clk); #1 clr_stats = 1'b0;
        tests++;
        if (txn_cnt !== 32'd0 || err_acc !== 32'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_wins: txn=%0d err=%0d out_valid=%b, expected 0, 0, 0", txn_cnt, err_acc, out_valid);
        end
        A = 8'd3; B = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (txn_cnt !== 32'd1 || err_acc !== 32'd2) begin
            fails++;
            $display("FAIL post_clear: txn=%0d err=%0d, expected 1, 2", txn_cnt, err_acc);
        end
    endtask

    task automatic test_saturation();
        stim_t s;
        bit    to;
        do_reset();
        s.a = 8'd3; s.b = 8'd3; s.m = 1'b0;
        repeat (7) st_q.push_back(s);
        drive_stream(100, 200, to);
        tests++;
        if (to || err_c4 !== 4'd14 || txn_c4 !== 4'd7) begin
            fails++;
            $display("FAIL sat_below: timeout=%0d err=%0d txn=%0d, expected 0, 14, 7", to, err_c4, txn_c4);
        end
        st_q.push_back(s);
        drive_stream(100, 200, to);
        tests++;
        if (to || err_c4 !== 4'd15 || txn_c4 !== 4'd8) begin
            fails++;
            $display("FAIL sat_edge: timeout=%0d err=%0d txn=%0d, expected 0, 15, 8", to, err_c4, txn_c4);
        end
        s.a = 8'd255; s.b = 8'd255;
        repeat (10) st_q.push_back(s);
        drive_stream(70, 400, to);
        tests++;
        if (to || err_c4 !== 4'd15 || txn_c4 !== 4'd2 || err_acc !== 32'd30756) begin
            fails++;
            $display("FAIL sat_hold: timeout=%0d err4=%0d txn4=%0d err32=%0d, expected 0, 15, 2, 30756",
                     to, err_c4, txn_c4, err_acc);
        end
    endtask

    task automatic test_reset_midflight();
        stim_t s;
        bit    to;
        for (int i = 0; i < 4; i++) begin
            A = 8'(8'd50 + i); B = 8'd99; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
        end
        tests++;
        if (sb_q.size() !== 3 || txn_cnt === 32'd0) begin
            fails++;
            $display("FAIL pre_reset: in flight=%0d txn=%0d, expected 3 and nonzero", sb_q.size(), txn_cnt);
        end
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || R !== 16'd0 || E !== 16'd0 || txn_cnt !== 32'd0 ||
            err_acc !== 32'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: out_valid=%b R=%0d E=%0d txn=%0d err=%0d in_ready=%b, expected 0,0,0,0,0,1",
                     out_valid, R, E, txn_cnt, err_acc, in_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL stale_output: out_valid=%b R=%0d, expected no output after reset", out_valid, R);
            end
        end
        @(posedge clk); #1;
        s.a = 8'd200; s.b = 8'd173; s.m = 1'b0;
        st_q.push_back(s);
        drive_stream(100, 100, to);
        tests++;
        if (to || txn_cnt !== 32'd1) begin
            fails++;
            $display("FAIL after_reset: timeout=%0d txn=%0d, expected 0 and 1", to, txn_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_sweep();
        test_clr_stats();
        test_saturation();
        test_reset_midflight();
        tests++;
        if (sb_q.size() !== 0) begin
            fails++;
            $display("FAIL leftover: %0d expected results never produced", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
